// File: rtl/demux116_pkg.sv
// Shared constants for the 1:16 serial-to-parallel deserializer cell.
package demux116_pkg;
  localparam int SLOT_W = 4;
  localparam int WORD_W = 16;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 4'd15;
endpackage

// File: rtl/demux116_slot_cnt.sv
// Slot counter: tracks which bit of the current word the next valid D fills.
module demux116_slot_cnt
  import demux116_pkg::*;
(
  input  logic              CK,
  input  logic              RST,
  input  logic              DV,
  input  logic              SYNC,
  output logic [SLOT_W-1:0] SD,
  output logic              LAST
);

  logic [SLOT_W-1:0] sd_q;
  logic [SLOT_W-1:0] sd_d;

  // SYNC with DV fills slot 0 on the same edge, so the count lands on 1.
  always_comb begin
    sd_d = sd_q;
    if (SYNC) begin
      sd_d = DV ? SLOT_W'(1) : '0;
    end else if (DV) begin
      sd_d = sd_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      sd_q <= '0;
    end else begin
      sd_q <= sd_d;
    end
  end

  assign SD   = sd_q;
  assign LAST = DV & ~SYNC & (sd_q == SLOT_LAST);

endmodule

// File: rtl/demux116_deser.sv
// 1:16 deserializer: shifts serial bits into a shadow word and hands completed
// words to a valid/ready output register with a sticky overflow flag.
module demux116_deser
  import demux116_pkg::*;
#(
  parameter int WORD_W = demux116_pkg::WORD_W,
  parameter int SLOT_W = demux116_pkg::SLOT_W
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              D,
  input  logic              DV,
  input  logic              SYNC,
  input  logic              QRDY,
  output logic [SLOT_W-1:0] SD,
  output logic [WORD_W-1:0] Q,
  output logic              QV,
  output logic              OVF
);

  // Handshake: Q is offered while QV=1 and is consumed on an edge with QRDY=1.
  logic              last;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] q_q, q_d;
  logic              qv_q, qv_d;
  logic              ovf_q, ovf_d;

  demux116_slot_cnt u_slot_cnt (
    .CK   (CK),
    .RST  (RST),
    .DV   (DV),
    .SYNC (SYNC),
    .SD   (SD),
    .LAST (last)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (SYNC) begin
      shadow_d = '0;
      if (DV) shadow_d[0] = D;
    end else if (DV) begin
      shadow_d[SD] = D;
    end
  end

  // A completing word is dropped only when the previous one is still unaccepted.
  always_comb begin
    q_d   = q_q;
    qv_d  = qv_q;
    ovf_d = ovf_q;
    if (last) begin
      if (qv_q && !QRDY) begin
        ovf_d = 1'b1;
      end else begin
        q_d  = {D, shadow_q[WORD_W-2:0]};
        qv_d = 1'b1;
      end
    end else if (qv_q && QRDY) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      shadow_q <= '0;
      q_q      <= '0;
      qv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      q_q      <= q_d;
      qv_q     <= qv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign QV  = qv_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_demux116_deser.sv
// Randomized scoreboard bench for demux116_deser with a bit-queue reference model.
module tb_demux116_deser;

  logic        CK, RST, D, DV, SYNC, QRDY;
  logic [3:0]  SD;
  logic [15:0] Q;
  logic        QV, OVF;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic        bit_q[$];
  logic        m_qv  = 1'b0;
  logic        m_ovf = 1'b0;

  demux116_deser dut (
    .CK   (CK),
    .RST  (RST),
    .D    (D),
    .DV   (DV),
    .SYNC (SYNC),
    .QRDY (QRDY),
    .SD   (SD),
    .Q    (Q),
    .QV   (QV),
    .OVF  (OVF)
  );

  // clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: collect bits since frame start; a word is 16 collected bits
  task automatic model_step(input logic r, input logic dv, input logic sy,
                            input logic d, input logic qr);
    logic        done;
    logic [15:0] w;
    done = 1'b0;
    w    = '0;
    if (r) begin
      bit_q.delete();
      exp_q.delete();
      m_qv  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (sy) begin
        bit_q.delete();
        if (dv) bit_q.push_back(d);
      end else if (dv) begin
        bit_q.push_back(d);
        if (bit_q.size() == 16) begin
          for (int i = 0; i < 16; i++) w[i] = bit_q[i];
          bit_q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (m_qv && !qr) m_ovf = 1'b1;
        else begin
          exp_q.push_back(w);
          m_qv = 1'b1;
        end
      end else if (m_qv && qr) begin
        m_qv = 1'b0;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, then model update and status checks
  task automatic cyc(input logic r, input logic dv, input logic sy,
                     input logic d, input logic qr);
    RST = r; DV = dv; SYNC = sy; D = d; QRDY = qr;
    @(posedge CK);
    model_step(r, dv, sy, d, qr);
    #1;
    chk("sd",  {12'd0, SD},  16'(bit_q.size()));
    chk("qv",  {15'd0, QV},  {15'd0, m_qv});
    chk("ovf", {15'd0, OVF}, {15'd0, m_ovf});
  endtask

  task automatic send_word(input logic [15:0] w, input logic qr_last);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, w[i], (i == 15) ? qr_last : 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  // monitor: an accepted word must match the oldest expected word
  always @(negedge CK) begin
    if (!RST && QV === 1'b1 && QRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept_unexpected: got %h expected none at %0t", Q, $time);
      end else begin
        chk("q_word", Q, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] w1, w2;
    int          left_bits, left_cyc;
    RST = 1'b1; DV = 1'b0; SYNC = 1'b0; D = 1'b0; QRDY = 1'b0;

    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_q", Q, 16'h0000);

    // fixed pattern, LSB first
    send_word(16'hA5C3, 1'b0);
    chk("pattern_q", Q, 16'hA5C3);
    drain();

    // mid-word realignment
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("sync_q0", {15'd0, Q[0]}, 16'd1);
    drain();

    // accept on the same edge the next word completes
    w1 = 16'($urandom); w2 = 16'($urandom);
    send_word(w1, 1'b0);
    send_word(w2, 1'b1);
    chk("same_edge_q", Q, w2);
    chk("same_edge_ovf", {15'd0, OVF}, 16'd0);
    drain();

    // back-to-back words with no acceptance
    w1 = 16'($urandom); w2 = 16'($urandom);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    chk("ovf_q_first", Q, w1);
    chk("ovf_set", {15'd0, OVF}, 16'd1);
    drain();

    // reset mid-word
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_q", Q, 16'h0000);
    send_word(16'hFFFF, 1'b0);
    chk("ones_q", Q, 16'hFFFF);
    drain();

    // sparse DV: 16 bits over 40 cycles
    w1 = 16'($urandom);
    left_bits = 16;
    for (left_cyc = 40; left_cyc > 0; left_cyc--) begin
      if (left_bits > 0 && (left_bits >= left_cyc || $urandom_range(0, 1) == 1)) begin
        cyc(1'b0, 1'b1, 1'b0, w1[16 - left_bits], 1'b0);
        left_bits--;
      end else begin
        cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    chk("sparse_q", Q, w1);
    drain();

    // free-running random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
